ram_arbiter: RTL and testbench

- Shares the single-port 256x16 data RAM (ram1) between two requesters.
- Port 0 is the instruction-fetch unit; port 1 is the load/store unit.
- Arbitrates each cycle, drives ram1's addr/din/we, and returns read data to the originating port with a fixed latency.
- Sits between the CPU core and ram1. Clocked by the same 100 MHz clk as ram1.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 33 +++
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the ram1 arbiter: default widths, port ids
// and the response-pipeline entry type.
package ram_arb_pkg;

    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 16;
    localparam int RD_LAT_DEF = 1;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LSU    = 1'b1;

    typedef struct packed {
        logic valid;
        logic port_id;
    } rsp_ent_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker with a last-grant register.
// Ports: clk, reset, req[1:0], accept (transfer happened), gnt[1:0] one-hot.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_grant;

    // Contention goes to the port that did not win last time.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (req == 2'b11)
                gnt = last_grant ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= PORT_LSU;
        else if (accept)
            last_grant <= gnt[1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares single-port ram1 between instruction fetch (port 0) and LSU (port 1).
// Ports: req/rsp handshakes per port, ram_addr/ram_din/ram_we to ram1, ram_dout back.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    logic [1:0]    gnt;
    logic          granted;
    logic          gport;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] hold0;
    logic [DW-1:0] hold1;
    rsp_ent_t      pipe [RD_LAT];
    rsp_ent_t      head;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .accept (granted),
        .gnt    (gnt)
    );

    // A grant is only issued to a valid port, so grant == accepted transfer.
    assign granted    = |gnt;
    assign gport      = gnt[1];
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        g_we    = req0_we;
        g_addr  = req0_addr;
        g_wdata = req0_wdata;
        if (gport) begin
            g_we    = req1_we;
            g_addr  = req1_addr;
            g_wdata = req1_wdata;
        end
    end

    // Idle cycles replay the last granted address/data from the register.
    always_comb begin
        ram_we   = granted & g_we;
        ram_addr = addr_q;
        ram_din  = din_q;
        if (granted) begin
            ram_addr = g_addr;
            ram_din  = g_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            din_q  <= '0;
        end else if (granted) begin
            addr_q <= g_addr;
            din_q  <= g_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: granted & ~g_we, port_id: gport};
            for (int i = 1; i < RD_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign head       = pipe[RD_LAT-1];
    assign rsp0_valid = head.valid && (head.port_id == PORT_IFETCH);
    assign rsp1_valid = head.valid && (head.port_id == PORT_LSU);

    // Read data passes straight through while valid, then is held.
    assign rsp0_rdata = rsp0_valid ? ram_dout : hold0;
    assign rsp1_rdata = rsp1_valid ? ram_dout : hold1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (rsp0_valid)
                hold0 <= ram_dout;
            if (rsp1_valid)
                hold1 <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter with a ram1 stand-in and a
// transaction-level reference model checked every cycle.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv [2];
    logic        rwe [2];
    logic [7:0]  ra [2];
    logic [15:0] rd [2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_rdata, rsp1_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout = '0;

    logic [15:0] mem [256];

    int passed = 0;
    int total = 0;

    // reference model state
    logic [15:0] mmem [256];
    int          m_last;
    logic [7:0]  m_laddr;
    logic [15:0] m_ldin;
    logic        m_pv;
    int          m_pp;
    logic [15:0] m_pd;
    logic [15:0] m_hold [2];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (rv[0]),
        .req0_we    (rwe[0]),
        .req0_addr  (ra[0]),
        .req0_wdata (rd[0]),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (rv[1]),
        .req1_we    (rwe[1]),
        .req1_addr  (ra[1]),
        .req1_wdata (rd[1]),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    // ram1 stand-in: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    // One call per negedge: compare DUT against the model, then
    // advance the model to what the coming edge will do.
    task automatic model_cycle();
        int g;
        logic          e_we;
        logic [7:0]    e_addr;
        logic [15:0]   e_din;
        logic          cv;
        logic [15:0]   ed;
        if (reset) begin
            m_last  = 1;
            m_laddr = '0;
            m_ldin  = '0;
            m_pv    = 1'b0;
            m_hold[0] = '0;
            m_hold[1] = '0;
            chk("rst_ctl", {req0_ready, req1_ready, ram_we,
                            rsp0_valid, rsp1_valid}, 0);
            chk("rst_addr", ram_addr, 0);
            chk("rst_din", ram_din, 0);
            chk("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
            return;
        end
        g = -1;
        if (rv[0] && rv[1])
            g = (m_last == 0) ? 1 : 0;
        else if (rv[0])
            g = 0;
        else if (rv[1])
            g = 1;
        e_we   = 1'b0;
        e_addr = m_laddr;
        e_din  = m_ldin;
        if (g >= 0) begin
            e_we   = rwe[g];
            e_addr = ra[g];
            e_din  = rd[g];
        end
        chk("ready0", req0_ready, g == 0);
        chk("ready1", req1_ready, g == 1);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, e_din);
        for (int p = 0; p < 2; p++) begin
            cv = m_pv && (m_pp == p);
            ed = cv ? m_pd : m_hold[p];
            if (p == 0) begin
                chk("rsp0_valid", rsp0_valid, cv);
                chk("rsp0_rdata", rsp0_rdata, ed);
            end else begin
                chk("rsp1_valid", rsp1_valid, cv);
                chk("rsp1_rdata", rsp1_rdata, ed);
            end
            m_hold[p] = ed;
        end
        m_pv = 1'b0;
        if (g >= 0) begin
            m_last  = g;
            m_laddr = ra[g];
            m_ldin  = rd[g];
            if (rwe[g]) begin
                mmem[ra[g]] = rd[g];
            end else begin
                m_pv = 1'b1;
                m_pp = g;
                m_pd = mmem[ra[g]];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic xfer(input int p, input logic we, input logic [7:0] a,
                        input logic [15:0] d);
        logic acc;
        int   n;
        rv[p] = 1'b1;
        rwe[p] = we;
        ra[p] = a;
        rd[p] = d;
        n = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = (p == 1) ? req1_ready : req0_ready;
            tick();
            n++;
        end while (!acc && n < 20);
        rv[p] = 1'b0;
        if (!acc)
            chk("xfer_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        logic acc0, acc1;
        int r;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mmem[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0;
            rwe[p] = 1'b0;
            ra[p] = '0;
            rd[p] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                model_cycle();
            end
        join_none

        repeat (2) tick();
        reset = 1'b0;

        // first contest after reset goes to port 0
        rv[0] = 1'b1; ra[0] = 8'h00;
        rv[1] = 1'b1; ra[1] = 8'hFF;
        @(negedge clk);
        chk("first_contest", {req1_ready, req0_ready}, 2'b01);
        tick();
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        repeat (2) tick();

        // port 1 write then read back
        xfer(1, 1'b1, 8'h10, 16'hBEEF);
        xfer(1, 1'b0, 8'h10, 16'h0);
        chk("t1_rsp1_valid", rsp1_valid, 1);
        chk("t1_rsp1_rdata", rsp1_rdata, 16'hBEEF);
        chk("t1_rsp0_valid", rsp0_valid, 0);
        tick();

        // preload boundary addresses, then both ports read for 8 cycles
        xfer(0, 1'b1, 8'h00, 16'h1111);
        xfer(1, 1'b1, 8'hFF, 16'h2222);
        rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 8'h00;
        rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 8'hFF;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                rv[0] = 1'b0;
                rv[1] = 1'b0;
            end
            @(negedge clk);
            if (i < 8)
                chk("t2_alternate", {req1_ready, req0_ready},
                    (i % 2 == 1) ? 2'b10 : 2'b01);
            if (rsp0_valid) begin
                c0++;
                chk("t2_rsp0_data", rsp0_rdata, 16'h1111);
            end
            if (rsp1_valid) begin
                c1++;
                chk("t2_rsp1_data", rsp1_rdata, 16'h2222);
            end
            tick();
        end
        chk("t2_rsp0_pulses", c0, 4);
        chk("t2_rsp1_pulses", c1, 4);

        // write on port 0 immediately followed by read on port 1
        xfer(0, 1'b1, 8'h20, 16'h5A5A);
        xfer(1, 1'b0, 8'h20, 16'h0);
        chk("t3_fwd_rdata", rsp1_rdata, 16'h5A5A);

        // idle keeps the last granted address on the bus
        xfer(1, 1'b0, 8'hFF, 16'h0);
        chk("t6_ff_rdata", rsp1_rdata, 16'h2222);
        repeat (5) tick();
        chk("t6_idle_addr", ram_addr, 8'hFF);
        chk("t6_idle_we", ram_we, 0);
        xfer(0, 1'b1, 8'h00, 16'hA0A0);
        xfer(0, 1'b0, 8'h00, 16'h0);
        chk("t6_00_rdata", rsp0_rdata, 16'hA0A0);

        // reset while a read response is in flight
        tick();
        xfer(0, 1'b0, 8'h20, 16'h0);
        chk("t5_pre_rsp", rsp0_valid, 1);
        reset = 1'b1;
        #1;
        chk("t5_async_ctl", {req0_ready, req1_ready, ram_we,
                             rsp0_valid, rsp1_valid}, 0);
        chk("t5_async_rdata", {rsp0_rdata, rsp1_rdata}, 0);
        chk("t5_async_addr", ram_addr, 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        xfer(1, 1'b0, 8'h10, 16'h0);
        chk("t5_ram_kept", rsp1_rdata, 16'hBEEF);

        // randomized traffic, holding each request until accepted
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc0 = req0_ready;
            acc1 = req1_ready;
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!rv[p] || (p == 0 ? acc0 : acc1)) begin
                    rv[p]  = ($urandom_range(0, 3) != 0);
                    rwe[p] = 1'($urandom_range(0, 1));
                    r      = $urandom_range(0, 9);
                    ra[p]  = (r == 9) ? 8'hFF : 8'(r);
                    rd[p]  = 16'($urandom);
                end
            end
        end
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
